uart_rx_byte: RTL and testbench

//   8N1 UART receiver. Deserialises the serial line into bytes and emits a
//   one-clock strobe per good byte. Sits directly upstream of the frame

---
 rtl/uart_rx_byte.sv | 181 ++++++++++++++++++
 tb/tb_uart_rx_byte.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_byte.sv
// ---------------------------------------------------------------------------
// uart_rx_byte
//   8N1 UART receiver. The serial line is oversampled 16x. Each bit is the
//   majority of three samples taken near the bit centre. Each good byte is
//   presented on 'data' together with a one-clock 'recieve' strobe.
//
// Ports
//   clk        in   1  system clock, rising edge
//   rst        in   1  synchronous, active-high reset
//   rx         in   1  asynchronous serial line, idle high
//   data       out  8  last good byte, held until the next good byte
//   recieve    out  1  one-clock pulse: 'data' was updated this cycle
//   frame_err  out  1  one-clock pulse: stop bit was low, byte discarded
//   busy       out  1  high while the receiver FSM is not idle
//
// Valid/ready semantics: there is no back-pressure. 'recieve' is a
// single-cycle valid. 'data' is stable from that cycle until the next
// 'recieve'. 'recieve' and 'frame_err' are mutually exclusive, and neither
// is asserted on two consecutive cycles.
// ---------------------------------------------------------------------------
module uart_rx_byte #(
    parameter int CLK_FREQ = 50_000_000,
    parameter int BAUD     = 9600
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] data,
    output logic       recieve,
    output logic       frame_err,
    output logic       busy
);

    localparam int DIV_RAW = CLK_FREQ / (BAUD * 16);
    localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam int DW      = (DIV > 1) ? $clog2(DIV) : 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd3,
        S_BREAK = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic        sync1_q, rx_s;
    logic [DW-1:0] div_q, div_d;
    logic [3:0]  scnt_q, scnt_d;
    logic        s7_q, s7_d, s8_q, s8_d;
    logic [2:0]  bidx_q, bidx_d;
    logic [7:0]  shift_q, shift_d;
    logic [7:0]  data_q, data_d;
    logic        recv_q, recv_d;
    logic        ferr_q, ferr_d;
    logic [3:0]  brk_q, brk_d;

    logic        tick;
    logic        decide;
    logic        maj;

    assign tick   = (div_q == DW'(DIV - 1));
    // The bit decision falls on the tick that carries the third sample.
    assign decide = tick && (scnt_q == 4'd9);
    assign maj    = (s7_q & s8_q) | (s7_q & rx_s) | (s8_q & rx_s);

    // State register and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            sync1_q <= 1'b1;
            rx_s    <= 1'b1;
            div_q   <= '0;
            scnt_q  <= '0;
            s7_q    <= 1'b0;
            s8_q    <= 1'b0;
            bidx_q  <= '0;
            shift_q <= '0;
            data_q  <= '0;
            recv_q  <= 1'b0;
            ferr_q  <= 1'b0;
            brk_q   <= '0;
        end else begin
            state_q <= state_d;
            sync1_q <= rx;
            rx_s    <= sync1_q;
            div_q   <= div_d;
            scnt_q  <= scnt_d;
            s7_q    <= s7_d;
            s8_q    <= s8_d;
            bidx_q  <= bidx_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            recv_q  <= recv_d;
            ferr_q  <= ferr_d;
            brk_q   <= brk_d;
        end
    end

    // Next-state and next-datapath logic.
    always_comb begin
        state_d = state_q;
        div_d   = tick ? '0 : div_q + DW'(1);
        scnt_d  = scnt_q;
        s7_d    = s7_q;
        s8_d    = s8_q;
        bidx_d  = bidx_q;
        shift_d = shift_q;
        data_d  = data_q;
        recv_d  = 1'b0;
        ferr_d  = 1'b0;
        brk_d   = brk_q;

        if (tick) begin
            scnt_d = scnt_q + 4'd1;
            if (scnt_q == 4'd7) s7_d = rx_s;
            if (scnt_q == 4'd8) s8_d = rx_s;
        end

        case (state_q)
            S_IDLE: begin
                scnt_d = '0;
                if (!rx_s) begin
                    // Restart the divider so tick phase aligns to the start edge.
                    state_d = S_START;
                    div_d   = '0;
                end
            end
            S_START: begin
                if (decide) begin
                    if (!maj) begin
                        state_d = S_DATA;
                        bidx_d  = '0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_DATA: begin
                if (decide) begin
                    shift_d = {maj, shift_q[7:1]};
                    bidx_d  = bidx_q + 3'd1;
                    if (bidx_q == 3'd7) state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (decide) begin
                    if (maj) begin
                        data_d  = shift_q;
                        recv_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        brk_d   = '0;
                        state_d = S_BREAK;
                    end
                end
            end
            S_BREAK: begin
                // Any low clock on the line restarts the count of high ticks.
                if (!rx_s) begin
                    brk_d = '0;
                end else if (tick) begin
                    if (brk_q == 4'd15) begin
                        brk_d   = '0;
                        state_d = S_IDLE;
                    end else begin
                        brk_d = brk_q + 4'd1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign data      = data_q;
    assign recieve   = recv_q;
    assign frame_err = ferr_q;
    assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_byte.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_byte
//   Directed bench for uart_rx_byte at 32 clocks per bit. Stimulus pushes the
//   expected strobe ({is_frame_err, data}) into exp_q. A monitor pops the
//   queue and compares it whenever recieve or frame_err pulses.
// ---------------------------------------------------------------------------
module tb_uart_rx_byte;

    localparam int BIT = 32;

    logic       clk;
    logic       rst;
    logic       rx;
    logic [7:0] data;
    logic       recieve;
    logic       frame_err;
    logic       busy;

    int n_total  = 0;
    int n_passed = 0;

    logic [8:0] exp_q[$];
    logic       prev_pulse;

    uart_rx_byte #(
        .CLK_FREQ(3_200_000),
        .BAUD    (100_000)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rx       (rx),
        .data     (data),
        .recieve  (recieve),
        .frame_err(frame_err),
        .busy     (busy)
    );

    // Clock and reset.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
    endtask

    // Drive one 8N1 frame. glitch_bit >= 0 inverts rx for one clock at the
    // centre of that data bit.
    task automatic send_frame(input logic [7:0] b, input logic stop, input int glitch_bit);
        rx = 1'b0;
        wait_clks(BIT);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            if (i == glitch_bit) begin
                wait_clks(BIT / 2);
                rx = ~b[i];
                wait_clks(1);
                rx = b[i];
                wait_clks(BIT / 2 - 1);
            end else begin
                wait_clks(BIT);
            end
        end
        rx = stop;
        wait_clks(BIT);
    endtask

    task automatic expect_byte(input logic [7:0] b);
        exp_q.push_back({1'b0, b});
    endtask

    // Scoreboard monitor: samples on the falling edge.
    always @(negedge clk) begin
        if (rst) begin
            prev_pulse <= 1'b0;
        end else begin
            if (recieve || frame_err) begin
                check("no_double_strobe", {30'd0, recieve & frame_err, prev_pulse}, 32'd0);
                if (exp_q.size() == 0) begin
                    check("unexpected_strobe", {23'd0, frame_err, data}, 32'h1ff);
                end else begin
                    logic [8:0] e;
                    e = exp_q.pop_front();
                    check(frame_err ? "frame_err_strobe" : "recieve_data",
                          {23'd0, frame_err, data}, {23'd0, e});
                end
            end
            prev_pulse <= recieve | frame_err;
        end
    end

    initial begin
        rst = 1'b1;
        rx  = 1'b1;
        wait_clks(4);
        rst = 1'b0;
        @(negedge clk);
        check("reset_data", {24'd0, data}, 32'h00);
        check("reset_recieve", {31'd0, recieve}, 32'd0);
        check("reset_frame_err", {31'd0, frame_err}, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        wait_clks(BIT);

        // 1. Single byte.
        expect_byte(8'hA5);
        send_frame(8'hA5, 1'b1, -1);
        wait_clks(BIT);

        // 2. Back-to-back frames, no idle gap.
        expect_byte(8'h0D);
        expect_byte(8'h0A);
        send_frame(8'h0D, 1'b1, -1);
        send_frame(8'h0A, 1'b1, -1);
        wait_clks(BIT);

        // 3. Short low pulse is rejected in START.
        rx = 1'b0;
        wait_clks(5);
        rx = 1'b1;
        wait_clks(2);
        @(negedge clk);
        check("glitch_busy_high", {31'd0, busy}, 32'd1);
        wait_clks(BIT);
        @(negedge clk);
        check("glitch_busy_low", {31'd0, busy}, 32'd0);
        wait_clks(BIT);

        // 4. Framing error, line held low, then recovery.
        exp_q.push_back({1'b1, 8'h0A});
        send_frame(8'h3C, 1'b0, -1);
        wait_clks(3 * BIT);
        rx = 1'b1;
        wait_clks(20);
        @(negedge clk);
        check("break_still_busy", {31'd0, busy}, 32'd1);
        wait_clks(30);
        @(negedge clk);
        check("break_released", {31'd0, busy}, 32'd0);
        check("data_held_after_ferr", {24'd0, data}, 32'h0A);
        wait_clks(BIT);
        expect_byte(8'h55);
        send_frame(8'h55, 1'b1, -1);
        wait_clks(BIT);

        // 5. One-clock glitch in the middle of data bit 3.
        expect_byte(8'hF0);
        send_frame(8'hF0, 1'b1, 3);
        wait_clks(BIT);

        // 6. Reset during data bit 4; partial byte must be dropped.
        rx = 1'b0;
        wait_clks(BIT);
        for (int i = 0; i < 4; i++) begin
            rx = i[0];
            wait_clks(BIT);
        end
        rx = 1'b1;
        wait_clks(BIT / 2);
        rst = 1'b1;
        wait_clks(1);
        rst = 1'b0;
        @(negedge clk);
        check("midrst_data", {24'd0, data}, 32'h00);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_strobes", {30'd0, recieve, frame_err}, 32'd0);
        wait_clks(2 * BIT);
        expect_byte(8'h81);
        send_frame(8'h81, 1'b1, -1);
        wait_clks(2 * BIT);

        check("all_strobes_seen", exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_passed, n_total);
        $finish;
    end

endmodule
